// File: rtl/keccak_pad_absorber.sv
// keccak_pad_absorber: packs byte beats into rate-sized blocks and applies the
// Keccak multi-rate padding (domain suffix at the message end, 0x80 at the last rate byte).
// Optional feature macro: KECCAK_PAD_BLOCK_CNT_EN adds the block_cnt_o handshake counter.
module keccak_pad_absorber #(
    parameter int IN_BYTES       = 8,
    parameter int MAX_RATE_BYTES = 168,
    parameter int RATE_WIDTH     = 11,
    parameter int SUFFIX_WIDTH   = 8
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          start_i,
    input  logic [RATE_WIDTH-1:0]         rate_i,
    input  logic [SUFFIX_WIDTH-1:0]       suffix_i,
    input  logic                          in_valid_i,
    output logic                          in_ready_o,
    input  logic [8*IN_BYTES-1:0]         in_data_i,
    input  logic [$clog2(IN_BYTES+1)-1:0] in_keep_i,
    input  logic                          in_last_i,
    output logic                          block_valid_o,
    input  logic                          block_ready_i,
    output logic [8*MAX_RATE_BYTES-1:0]   block_o,
    output logic                          block_final_o,
    output logic                          busy_o
`ifdef KECCAK_PAD_BLOCK_CNT_EN
    ,
    output logic [15:0]                   block_cnt_o
`endif
);

    localparam int PTR_W = $clog2(MAX_RATE_BYTES + 1);

    typedef enum logic [1:0] {IDLE, ABSORB, PAD, EMIT} state_t;

    state_t                  state_reg;
    logic [7:0]              rate_buf_reg [MAX_RATE_BYTES];
    logic [PTR_W-1:0]        ptr_reg;
    logic [PTR_W-1:0]        rate_bytes_reg;
    logic [SUFFIX_WIDTH-1:0] suffix_reg;
    logic                    final_reg;
    logic                    pend_reg;

    logic [PTR_W-1:0]        ptr_next;
    logic [PTR_W-1:0]        last_idx;
    logic                    unused_rate_bits;

    // Rate is a multiple of 64 bits, so the low three bits carry no information.
    assign unused_rate_bits = ^rate_i[2:0];
    assign ptr_next         = ptr_reg + PTR_W'(in_keep_i);
    assign last_idx         = rate_bytes_reg - PTR_W'(1);

    // Main FSM: absorbs beats into the buffer, pads, and holds blocks for the handshake.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg      <= IDLE;
            ptr_reg        <= '0;
            rate_bytes_reg <= '0;
            suffix_reg     <= '0;
            final_reg      <= 1'b0;
            pend_reg       <= 1'b0;
            for (int j = 0; j < MAX_RATE_BYTES; j++) rate_buf_reg[j] <= 8'h00;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (start_i) begin
                        rate_bytes_reg <= PTR_W'(rate_i[RATE_WIDTH-1:3]);
                        suffix_reg     <= suffix_i;
                        ptr_reg        <= '0;
                        final_reg      <= 1'b0;
                        pend_reg       <= 1'b0;
                        for (int j = 0; j < MAX_RATE_BYTES; j++) rate_buf_reg[j] <= 8'h00;
                        state_reg      <= ABSORB;
                    end
                end
                ABSORB: begin
                    if (in_valid_i) begin
                        for (int b = 0; b < IN_BYTES; b++) begin
                            if (b < int'(in_keep_i))
                                rate_buf_reg[ptr_reg + PTR_W'(b)] <= in_data_i[b*8 +: 8];
                        end
                        ptr_reg <= ptr_next;
                        if (in_last_i) begin
                            if (ptr_next == rate_bytes_reg) begin
                                // Full block ends the message: emit it, then a pad-only block.
                                pend_reg  <= 1'b1;
                                final_reg <= 1'b0;
                                state_reg <= EMIT;
                            end else begin
                                state_reg <= PAD;
                            end
                        end else if (ptr_next == rate_bytes_reg) begin
                            final_reg <= 1'b0;
                            state_reg <= EMIT;
                        end
                    end
                end
                PAD: begin
                    if (ptr_reg == last_idx) begin
                        rate_buf_reg[last_idx] <= rate_buf_reg[last_idx] ^ suffix_reg[7:0] ^ 8'h80;
                    end else begin
                        rate_buf_reg[ptr_reg]  <= rate_buf_reg[ptr_reg] ^ suffix_reg[7:0];
                        rate_buf_reg[last_idx] <= rate_buf_reg[last_idx] ^ 8'h80;
                    end
                    final_reg <= 1'b1;
                    pend_reg  <= 1'b0;
                    state_reg <= EMIT;
                end
                EMIT: begin
                    if (block_ready_i) begin
                        ptr_reg <= '0;
                        for (int j = 0; j < MAX_RATE_BYTES; j++) rate_buf_reg[j] <= 8'h00;
                        if (final_reg)     state_reg <= IDLE;
                        else if (pend_reg) state_reg <= PAD;
                        else               state_reg <= ABSORB;
                    end
                end
                default: state_reg <= IDLE;
            endcase
        end
    end

`ifdef KECCAK_PAD_BLOCK_CNT_EN
    logic [15:0] block_cnt_reg;

    // Counts block handshakes since the most recent accepted start.
    always_ff @(posedge clk) begin
        if (rst)
            block_cnt_reg <= 16'h0000;
        else if (state_reg == IDLE && start_i)
            block_cnt_reg <= 16'h0000;
        else if (state_reg == EMIT && block_ready_i)
            block_cnt_reg <= block_cnt_reg + 16'h0001;
    end

    assign block_cnt_o = block_cnt_reg;
`endif

    assign in_ready_o    = (state_reg == ABSORB);
    assign block_valid_o = (state_reg == EMIT);
    assign block_final_o = (state_reg == EMIT) && final_reg;
    assign busy_o        = (state_reg != IDLE);

    // Flatten the byte buffer; bytes beyond the rate are never written and stay zero.
    generate
        for (genvar gi = 0; gi < MAX_RATE_BYTES; gi++) begin : g_flat
            assign block_o[gi*8 +: 8] = rate_buf_reg[gi];
        end
    endgenerate

endmodule

// File: tb/tb_keccak_pad_absorber.sv
// Testbench for keccak_pad_absorber: random messages against a byte-level padding model.
module tb_keccak_pad_absorber;

    localparam int IB = 8;
    localparam int MR = 168;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              start_i = 1'b0;
    logic [10:0]       rate_i = '0;
    logic [7:0]        suffix_i = '0;
    logic              in_valid_i = 1'b0;
    logic              in_ready_o;
    logic [8*IB-1:0]   in_data_i = '0;
    logic [3:0]        in_keep_i = '0;
    logic              in_last_i = 1'b0;
    logic              block_valid_o;
    logic              block_ready_i = 1'b0;
    logic [8*MR-1:0]   block_o;
    logic              block_final_o;
    logic              busy_o;
`ifdef KECCAK_PAD_BLOCK_CNT_EN
    logic [15:0]       block_cnt_o;
`endif

    int checks = 0;
    int failures = 0;
    int cyc = 0;

    logic [7:0]      msg [512];
    logic [8*MR-1:0] exp_blk [8];
    logic [8*MR-1:0] last_block;
    int              blocks_done;

    keccak_pad_absorber #(.IN_BYTES(IB), .MAX_RATE_BYTES(MR)) dut (
        .clk(clk), .rst(rst), .start_i(start_i), .rate_i(rate_i), .suffix_i(suffix_i),
        .in_valid_i(in_valid_i), .in_ready_o(in_ready_o), .in_data_i(in_data_i),
        .in_keep_i(in_keep_i), .in_last_i(in_last_i), .block_valid_o(block_valid_o),
        .block_ready_i(block_ready_i), .block_o(block_o), .block_final_o(block_final_o),
        .busy_o(busy_o)
`ifdef KECCAK_PAD_BLOCK_CNT_EN
        , .block_cnt_o(block_cnt_o)
`endif
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Runs one full message; expected blocks come from the padding rule applied to the byte string.
    task automatic run_msg(input string name, input int rate_bits, input logic [7:0] sfx,
                           input int len, input bit stall, input bit noise);
        int r, nblk, rem, sent, mptr, bs, exp_cyc, budget, keep, bad;
        bit done_in, fresh, last;
        r = rate_bits / 8;
        nblk = len / r + 1;
        for (int k = 0; k < nblk; k++) begin
            exp_blk[k] = '0;
            for (int i = 0; i < r; i++)
                if (k * r + i < len) exp_blk[k][i*8 +: 8] = msg[k*r+i];
            if (k == nblk - 1) begin
                rem = len - k * r;
                exp_blk[k][rem*8 +: 8] = exp_blk[k][rem*8 +: 8] ^ sfx;
                exp_blk[k][(r-1)*8 +: 8] = exp_blk[k][(r-1)*8 +: 8] ^ 8'h80;
            end
        end
        @(negedge clk);
        start_i = 1'b1; rate_i = 11'(rate_bits); suffix_i = sfx;
        @(negedge clk);
        start_i = 1'b0;
        sent = 0; mptr = 0; bs = 0; exp_cyc = -1; budget = 5000;
        done_in = 1'b0; fresh = 1'b1; blocks_done = 0;
        while (bs < nblk && budget > 0) begin
            block_ready_i = 1'b0;
            in_valid_i = 1'b0;
            if (block_valid_o) begin
                checks++;
                if (in_ready_o !== 1'b0) begin
                    failures++;
                    $display("FAIL %s ready_in_emit got=%b want=0", name, in_ready_o);
                end
                checks++;
                if (block_o !== exp_blk[bs]) begin
                    failures++;
                    bad = 0;
                    for (int i = MR - 1; i >= 0; i--)
                        if (block_o[i*8 +: 8] !== exp_blk[bs][i*8 +: 8]) bad = i;
                    $display("FAIL %s block%0d byte%0d got=%02h want=%02h", name, bs, bad,
                             block_o[bad*8 +: 8], exp_blk[bs][bad*8 +: 8]);
                end
                checks++;
                if (block_final_o !== (bs == nblk - 1)) begin
                    failures++;
                    $display("FAIL %s final%0d got=%b want=%b", name, bs, block_final_o, bs == nblk - 1);
                end
                if (fresh && exp_cyc >= 0) begin
                    checks++;
                    if (cyc != exp_cyc) begin
                        failures++;
                        $display("FAIL %s latency%0d got=%0d want=%0d", name, bs, cyc, exp_cyc);
                    end
                end
                fresh = 1'b0;
                if (!stall || ($urandom % 2) == 0) begin
                    block_ready_i = 1'b1;
                    last_block = block_o;
                    bs++;
                    blocks_done++;
                    fresh = 1'b1;
                    exp_cyc = (done_in && bs == nblk - 1) ? cyc + 2 : -1;
                end
            end
            if (in_ready_o && !done_in && (!noise || ($urandom % 4) != 0)) begin
                rem = len - sent;
                keep = (rem >= IB) ? IB : rem;
                last = (rem <= IB);
                for (int b = 0; b < IB; b++)
                    in_data_i[b*8 +: 8] = (b < keep) ? msg[sent+b] : 8'($urandom);
                in_keep_i = 4'(keep);
                in_last_i = last;
                in_valid_i = 1'b1;
                sent += keep;
                mptr += keep;
                if (last) begin
                    exp_cyc = (mptr == r) ? cyc + 1 : cyc + 2;
                    done_in = 1'b1;
                end else if (mptr == r) begin
                    exp_cyc = cyc + 1;
                end
                if (mptr == r) mptr = 0;
            end
            if (noise) begin
                start_i = 1'($urandom);
                rate_i = 11'($urandom);
                suffix_i = 8'($urandom);
            end
            @(negedge clk);
            budget--;
        end
        start_i = 1'b0; block_ready_i = 1'b0; in_valid_i = 1'b0;
        checks++;
        if (budget == 0) begin
            failures++;
            $display("FAIL %s timeout blocks got=%0d want=%0d", name, bs, nblk);
        end
        checks++;
        if (busy_o !== 1'b0 || block_valid_o !== 1'b0) begin
            failures++;
            $display("FAIL %s idle_after busy=%b valid=%b want=0", name, busy_o, block_valid_o);
        end
`ifdef KECCAK_PAD_BLOCK_CNT_EN
        checks++;
        if (block_cnt_o !== 16'(nblk)) begin
            failures++;
            $display("FAIL %s block_cnt got=%0d want=%0d", name, block_cnt_o, nblk);
        end
`endif
        $display("msg %s rate=%0d len=%0d blocks=%0d", name, rate_bits, len, blocks_done);
    endtask

    task automatic test_reset();
        @(negedge clk);
        checks++;
        if (in_ready_o !== 1'b0 || block_valid_o !== 1'b0 || block_final_o !== 1'b0 ||
            busy_o !== 1'b0 || block_o !== '0) begin
            failures++;
            $display("FAIL reset_state rdy=%b val=%b fin=%b busy=%b blk_nz=%b want=all0",
                     in_ready_o, block_valid_o, block_final_o, busy_o, |block_o);
        end
        $display("reset checked");
    endtask

    task automatic test_abc();
        msg[0] = 8'h61; msg[1] = 8'h62; msg[2] = 8'h63;
        run_msg("abc", 1088, 8'h06, 3, 1'b0, 1'b0);
        checks++;
        if (last_block[31:0] !== 32'h06636261 || last_block[135*8 +: 8] !== 8'h80) begin
            failures++;
            $display("FAIL abc_bytes got=%08h/%02h want=06636261/80", last_block[31:0], last_block[135*8 +: 8]);
        end
    endtask

    task automatic test_135();
        for (int i = 0; i < 135; i++) msg[i] = 8'($urandom);
        run_msg("len135", 1088, 8'h06, 135, 1'b0, 1'b0);
        checks++;
        if (last_block[135*8 +: 8] !== 8'h86 || blocks_done != 1) begin
            failures++;
            $display("FAIL len135_byte135 got=%02h blocks=%0d want=86 blocks=1", last_block[135*8 +: 8], blocks_done);
        end
    endtask

    task automatic test_136();
        for (int i = 0; i < 136; i++) msg[i] = 8'($urandom);
        run_msg("len136", 1088, 8'h06, 136, 1'b1, 1'b0);
        checks++;
        if (last_block[7:0] !== 8'h06 || last_block[135*8 +: 8] !== 8'h80 || blocks_done != 2) begin
            failures++;
            $display("FAIL len136_pad got=%02h/%02h blocks=%0d want=06/80 blocks=2",
                     last_block[7:0], last_block[135*8 +: 8], blocks_done);
        end
    endtask

    task automatic test_empty();
        run_msg("empty", 1344, 8'h1F, 0, 1'b0, 1'b0);
        checks++;
        if (last_block[7:0] !== 8'h1F || last_block[167*8 +: 8] !== 8'h80) begin
            failures++;
            $display("FAIL empty_pad got=%02h/%02h want=1F/80", last_block[7:0], last_block[167*8 +: 8]);
        end
    endtask

    task automatic test_random();
        int rates [5] = '{576, 832, 1088, 1152, 1344};
        int len;
        for (int t = 0; t < 12; t++) begin
            len = $urandom_range(0, 320);
            for (int i = 0; i < len; i++) msg[i] = 8'($urandom);
            run_msg("random", rates[$urandom_range(0, 4)], 8'($urandom), len, 1'b1, 1'b1);
        end
    endtask

    task automatic test_stall_reset();
        logic [8*MR-1:0] want, hold;
        want = '0;
        @(negedge clk);
        start_i = 1'b1; rate_i = 11'd1088; suffix_i = 8'h06;
        @(negedge clk);
        start_i = 1'b0;
        for (int k = 0; k < 17; k++) begin
            for (int b = 0; b < IB; b++) in_data_i[b*8 +: 8] = 8'($urandom);
            want[k*64 +: 64] = in_data_i;
            in_keep_i = 4'd8; in_last_i = 1'b0; in_valid_i = 1'b1;
            @(negedge clk);
        end
        in_valid_i = 1'b0;
        hold = block_o;
        checks++;
        if (block_valid_o !== 1'b1 || block_final_o !== 1'b0 || block_o !== want) begin
            failures++;
            $display("FAIL stall_first val=%b fin=%b data_ok=%b want=1/0/1",
                     block_valid_o, block_final_o, block_o === want);
        end
        for (int c = 0; c < 10; c++) begin
            checks++;
            if (block_valid_o !== 1'b1 || in_ready_o !== 1'b0 || block_o !== hold) begin
                failures++;
                $display("FAIL stall_hold cyc%0d val=%b rdy=%b stable=%b want=1/0/1",
                         c, block_valid_o, in_ready_o, block_o === hold);
            end
            @(negedge clk);
        end
        block_ready_i = 1'b1;
        @(negedge clk);
        block_ready_i = 1'b0;
        checks++;
        if (in_ready_o !== 1'b1 || block_valid_o !== 1'b0 || block_o !== '0) begin
            failures++;
            $display("FAIL stall_release rdy=%b val=%b blk_nz=%b want=1/0/0", in_ready_o, block_valid_o, |block_o);
        end
        in_data_i = 64'h0123456789abcdef; in_keep_i = 4'd8; in_last_i = 1'b0; in_valid_i = 1'b1;
        @(negedge clk);
        in_valid_i = 1'b0;
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        checks++;
        if (in_ready_o !== 1'b0 || block_valid_o !== 1'b0 || block_final_o !== 1'b0 ||
            busy_o !== 1'b0 || block_o !== '0) begin
            failures++;
            $display("FAIL midrst_outputs rdy=%b val=%b fin=%b busy=%b blk_nz=%b want=all0",
                     in_ready_o, block_valid_o, block_final_o, busy_o, |block_o);
        end
        for (int c = 0; c < 20; c++) begin
            checks++;
            if (block_valid_o !== 1'b0 || busy_o !== 1'b0) begin
                failures++;
                $display("FAIL midrst_quiet cyc%0d val=%b busy=%b want=0", c, block_valid_o, busy_o);
            end
            @(negedge clk);
        end
        $display("stall/reset scenario done");
    endtask

    initial begin
        repeat (3) @(negedge clk);
        rst = 1'b0;
        test_reset();
        test_abc();
        test_135();
        test_136();
        test_empty();
        test_random();
        test_stall_reset();
        test_abc();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
